tqvp_reg_arbiter: RTL and testbench

Shares the single peripheral register port (4-bit address, 8-bit write data, write strobe, combinational read data) between NREQ requesters. Typical requesters are the SPI register bridge and an on-chip config sequencer. The block sits between the requesters and the peripheral under test. It round-robin arbitrates, sequences each access (address setup, write strobe or read wait, response), and returns a per-requester completion pulse with captured read data.

---
 rtl/tqvp_arb_pkg.sv | 18 +
 rtl/rr_arb_pick.sv | 28 ++
 rtl/tqvp_reg_arbiter.sv | 132 +++++++++++++
 tb/tb_tqvp_reg_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_arb_pkg.sv
// Shared types and default sizes for the peripheral register-port arbiter.
package tqvp_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StWait,
      StDone
   } arb_state_e;

   localparam int unsigned DefNreq     = 2;
   localparam int unsigned DefAddrW    = 4;
   localparam int unsigned DefDataW    = 8;
   localparam int unsigned DefReadWait = 1;
   // Wide enough for READ_WAIT up to 7.
   localparam int unsigned WaitCntW    = 3;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first asserted request after the pointer, with wrap.
module rr_arb_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IdxW = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IdxW-1:0] pointer,
   output logic            any,
   output logic [IdxW-1:0] winner
);

   int unsigned idx;

   // Scan pointer+1 .. pointer+NREQ modulo NREQ; the first hit wins.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(pointer) + k) % NREQ;
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/tqvp_reg_arbiter.sv
// Round-robin arbiter sharing one peripheral register port between NREQ requesters.
module tqvp_reg_arbiter
   import tqvp_arb_pkg::*;
#(
   parameter int unsigned NREQ      = DefNreq,
   parameter int unsigned ADDR_W    = DefAddrW,
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned READ_WAIT = DefReadWait,
   localparam int unsigned IdxW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   output logic [IdxW-1:0]        owner,
   output logic [ADDR_W-1:0]      address,
   output logic [DATA_W-1:0]      data_in,
   output logic                   data_write,
   input  logic [DATA_W-1:0]      data_out
);

   arb_state_e           state_q;
   logic [IdxW-1:0]      ptr_q;
   logic [IdxW-1:0]      owner_q;
   logic                 we_q;
   logic [WaitCntW-1:0]  cnt_q;
   logic [NREQ-1:0]      gnt_q;
   logic [NREQ-1:0]      rvalid_q;
   logic [DATA_W-1:0]    rdata_q;
   logic                 busy_q;
   logic [ADDR_W-1:0]    address_q;
   logic [DATA_W-1:0]    data_in_q;
   logic                 data_write_q;

   logic                 pick_any;
   logic [IdxW-1:0]      pick_idx;

   rr_arb_pick #(
      .NREQ (NREQ),
      .IdxW (IdxW)
   ) u_pick (
      .req     (req),
      .pointer (ptr_q),
      .any     (pick_any),
      .winner  (pick_idx)
   );

   // Transaction sequencer; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ptr_q        <= IdxW'(NREQ - 1);
         owner_q      <= IdxW'(NREQ - 1);
         we_q         <= 1'b0;
         cnt_q        <= '0;
         gnt_q        <= '0;
         rvalid_q     <= '0;
         rdata_q      <= '0;
         busy_q       <= 1'b0;
         address_q    <= '0;
         data_in_q    <= '0;
         data_write_q <= 1'b0;
      end else begin
         // Pulsed outputs default low every cycle.
         gnt_q        <= '0;
         rvalid_q     <= '0;
         data_write_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_any) begin
                  state_q          <= StAddr;
                  busy_q           <= 1'b1;
                  owner_q          <= pick_idx;
                  we_q             <= req_we[pick_idx];
                  address_q        <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                  data_in_q        <= req_wdata[pick_idx*DATA_W +: DATA_W];
                  gnt_q[pick_idx]  <= 1'b1;
                  // Strobe lines up with the ADDR cycle so address/data are already valid.
                  data_write_q     <= req_we[pick_idx];
               end
            end
            StAddr: begin
               if (we_q) begin
                  state_q           <= StDone;
                  rvalid_q[owner_q] <= 1'b1;
               end else if (READ_WAIT == 0) begin
                  state_q           <= StDone;
                  rdata_q           <= data_out;
                  rvalid_q[owner_q] <= 1'b1;
               end else begin
                  state_q <= StWait;
                  cnt_q   <= WaitCntW'(READ_WAIT - 1);
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  state_q           <= StDone;
                  rdata_q           <= data_out;
                  rvalid_q[owner_q] <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               ptr_q   <= owner_q;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign rvalid     = rvalid_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign owner      = owner_q;
   assign address    = address_q;
   assign data_in    = data_in_q;
   assign data_write = data_write_q;

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed bench for tqvp_reg_arbiter: READ_WAIT=1 main instance plus a READ_WAIT=0 instance.
module tb_tqvp_reg_arbiter;

   logic       clk = 1'b0;
   logic       rst;

   // Main instance (NREQ=2, READ_WAIT=1)
   logic [1:0]  req, req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        busy;
   logic [0:0]  owner;
   logic [3:0]  address;
   logic [7:0]  data_in;
   logic        data_write;
   logic [7:0]  data_out;

   // Zero-wait instance
   logic [1:0]  z_req, z_req_we;
   logic [7:0]  z_req_addr;
   logic [15:0] z_req_wdata;
   logic [1:0]  z_gnt, z_rvalid;
   logic [7:0]  z_rdata;
   logic        z_busy;
   logic [0:0]  z_owner;
   logic [3:0]  z_address;
   logic [7:0]  z_data_in;
   logic        z_data_write;
   logic [7:0]  z_data_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [16];

   always #5 clk = ~clk;

   tqvp_reg_arbiter #(
      .NREQ(2), .ADDR_W(4), .DATA_W(8), .READ_WAIT(1)
   ) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
      .owner(owner), .address(address), .data_in(data_in), .data_write(data_write),
      .data_out(data_out)
   );

   tqvp_reg_arbiter #(
      .NREQ(2), .ADDR_W(4), .DATA_W(8), .READ_WAIT(0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .req(z_req), .req_we(z_req_we), .req_addr(z_req_addr),
      .req_wdata(z_req_wdata), .gnt(z_gnt), .rvalid(z_rvalid), .rdata(z_rdata),
      .busy(z_busy), .owner(z_owner), .address(z_address), .data_in(z_data_in),
      .data_write(z_data_write), .data_out(z_data_out)
   );

   // Peripheral model: register file, address 5 hardwired to 8'h3C.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      end else if (data_write) begin
         mem[address] <= data_in;
      end
   end
   assign data_out   = (address == 4'h5) ? 8'h3C : mem[address];
   assign z_data_out = (z_address == 4'hF) ? 8'h81 : {4'h0, z_address};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      z_req = '0; z_req_we = '0; z_req_addr = '0; z_req_wdata = '0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 1);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_address", 32'(address), 0);
      chk("rst_data_write", 32'(data_write), 0);
      rst = 1'b0;
      tick();

      // Write from req0: addr 3, data A5
      req = 2'b01; req_we = 2'b01; req_addr[3:0] = 4'h3; req_wdata[7:0] = 8'hA5;
      tick();
      chk("wr_gnt", 32'(gnt), 32'h1);
      chk("wr_strobe", 32'(data_write), 1);
      chk("wr_addr", 32'(address), 32'h3);
      chk("wr_data_in", 32'(data_in), 32'hA5);
      chk("wr_busy", 32'(busy), 1);
      chk("wr_owner", 32'(owner), 0);
      req = 2'b00; req_addr[3:0] = 4'hE;
      tick();
      chk("wr_strobe_off", 32'(data_write), 0);
      chk("wr_gnt_off", 32'(gnt), 0);
      chk("wr_rvalid", 32'(rvalid), 32'h1);
      chk("wr_rdata_kept", 32'(rdata), 0);
      chk("wr_mem", 32'(mem[3]), 32'hA5);
      tick();
      chk("wr_rvalid_off", 32'(rvalid), 0);
      chk("wr_idle", 32'(busy), 0);
      chk("wr_addr_hold", 32'(address), 32'h3);

      // Read from req1: addr 5 -> 3C
      req = 2'b10; req_we = 2'b00; req_addr[7:4] = 4'h5;
      tick();
      chk("rd_gnt", 32'(gnt), 32'h2);
      chk("rd_owner", 32'(owner), 1);
      chk("rd_addr", 32'(address), 32'h5);
      chk("rd_strobe0", 32'(data_write), 0);
      req = 2'b00;
      tick();
      chk("rd_rvalid_early", 32'(rvalid), 0);
      chk("rd_strobe1", 32'(data_write), 0);
      tick();
      chk("rd_rvalid", 32'(rvalid), 32'h2);
      chk("rd_rdata", 32'(rdata), 32'h3C);
      chk("rd_strobe2", 32'(data_write), 0);
      tick();
      chk("rd_idle", 32'(busy), 0);

      // req1 pulsed during a req0 write is never granted
      req = 2'b01; req_we = 2'b01; req_addr[3:0] = 4'h7; req_wdata[7:0] = 8'h5A;
      tick();
      chk("pulse_gnt0", 32'(gnt), 32'h1);
      req = 2'b10; req_we = 2'b00;
      tick();
      chk("pulse_rvalid0", 32'(rvalid), 32'h1);
      req = 2'b00;
      tick();
      chk("pulse_idle", 32'(busy), 0);
      tick();
      chk("pulse_no_gnt", 32'(gnt), 0);
      chk("pulse_no_rvalid", 32'(rvalid), 0);
      chk("pulse_still_idle", 32'(busy), 0);

      // Reset during WAIT of a read from req1
      req = 2'b10; req_we = 2'b00; req_addr[7:4] = 4'h5;
      tick();
      chk("abort_gnt", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rvalid", 32'(rvalid), 0);
      chk("abort_rdata", 32'(rdata), 0);
      chk("abort_owner", 32'(owner), 1);
      tick();
      chk("abort_no_rvalid", 32'(rvalid), 0);

      // Both requesters held for four writes: grants alternate 0,1,0,1
      req = 2'b11; req_we = 2'b11;
      req_addr = {4'h2, 4'h1}; req_wdata = {8'h22, 8'h11};
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_owner", 32'(owner), 32'(k % 2));
         tick();
         chk("rr_rvalid", 32'(rvalid), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_gnt_gap", 32'(gnt), 0);
         if (k == 3) req = 2'b00;
         tick();
         chk("rr_idle_gnt", 32'(gnt), 0);
      end
      chk("rr_mem1", 32'(mem[1]), 32'h11);
      chk("rr_mem2", 32'(mem[2]), 32'h22);

      // READ_WAIT=0 instance: read addr F -> 81
      z_req = 2'b01; z_req_we = 2'b00; z_req_addr[3:0] = 4'hF;
      tick();
      chk("z_gnt", 32'(z_gnt), 32'h1);
      chk("z_addr", 32'(z_address), 32'hF);
      z_req = 2'b00;
      tick();
      chk("z_rvalid", 32'(z_rvalid), 32'h1);
      chk("z_rdata", 32'(z_rdata), 32'h81);
      chk("z_strobe", 32'(z_data_write), 0);
      tick();
      chk("z_idle", 32'(z_busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
